fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter / instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 9, instruction width.
REQ-003 SHALL have parameter HALT_INSTR, default 9'h1FF, instruction encoding that ends a program.
REQ-004 SHALL run on one clock and use a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins program execution.
REQ-008 start_addr  input  PC_W  first instruction address, sampled on the accepted start.
REQ-009 stall  input  1  holds PC and suppresses instr_valid for that cycle.
REQ-010 branch_taken  input  1  redirects the next PC to branch_target.
REQ-011 branch_target  input  PC_W  absolute branch destination.
REQ-012 imem_addr  output  PC_W  instruction memory address (combinational read), equal to pc.
REQ-013 imem_data  input  INSTR_W  instruction returned for imem_addr in the same cycle.
REQ-014 opcode  output  3  imem_data[8:6], passed to the control decoder.
REQ-015 last_bit  output  1  imem_data[0], the INC/DEC select bit.
REQ-016 operand  output  6  imem_data[5:0].
REQ-017 instr_valid  output  1  the current instruction is to be executed this cycle.
REQ-018 done  output  1  program halted; held until the next start or reset.
REQ-019 cycle_count  output  16  executed-instruction counter (see Configuration).

Function
REQ-020 SHALL implement states IDLE, RUN and DONE.
REQ-021 IDLE: start -> RUN; pc <= start_addr.
REQ-022 RUN: instr_valid = !stall && (imem_data != HALT_INSTR).
REQ-023 RUN with stall=1: pc holds; branch_taken ignored; HALT_INSTR not acted on.
REQ-024 RUN, !stall, imem_data == HALT_INSTR: -> DONE; pc holds; instr_valid=0 that cycle; done=1 from the next cycle.
REQ-025 RUN, !stall, branch_taken: pc <= branch_target (taken the cycle after the branch instruction is valid).
REQ-026 RUN, !stall, no branch: pc <= pc+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
REQ-027 Branch and halt on the same cycle: halt has priority.
REQ-028 start while in RUN: ignored.
REQ-029 start while in DONE: -> RUN; pc <= start_addr; done cleared the next cycle; cycle_count cleared.
REQ-030 opcode, last_bit and operand: raw slices in every state; consumers qualify them with instr_valid.
REQ-031 instr_valid=0 in IDLE and DONE.

Reset
REQ-032 Reset SHALL, on the next rising edge, force state=IDLE, pc=0, done=0, instr_valid=0 and cycle_count=0, overriding every other input.
REQ-033 Reset asserted in RUN SHALL abort the program with no further instr_valid.

Configuration
REQ-034 Macro FETCH_CYCLE_COUNT_EN defined: cycle_count increments on each cycle with instr_valid=1, saturates at 16'hFFFF, and clears on accepted start or reset.
REQ-035 FETCH_CYCLE_COUNT_EN undefined: cycle_count is tied to 16'h0000 and no counter register exists.

Structure
REQ-036 Package isa_pkg SHALL hold INSTR_W, the opcode field typedef, HALT_INSTR and the fetch_state_t enum (IDLE, RUN, DONE).
REQ-037 The counter SHALL be sub-module fetch_cycle_counter, instantiated only under FETCH_CYCLE_COUNT_EN.

Verification
REQ-038 Sequential run: reset, start with start_addr=5, memory 5..7 non-halt, 8=HALT -> imem_addr 5,6,7,8; instr_valid 1,1,1,0; done=1 the cycle after address 8; cycle_count=3 (with the macro).
REQ-039 Branch: at pc=2, branch_taken=1 with branch_target=40 -> next imem_addr=40.
REQ-040 Stall: stall=1 for 2 cycles at pc=10 -> imem_addr stays 10; instr_valid=0; cycle_count unchanged; pc=11 after release.
REQ-041 Wrap: start_addr=1023, no halt -> next pc=0.
REQ-042 Priority: HALT_INSTR with branch_taken=1 -> DONE; pc holds.
REQ-043 Abort and restart: reset mid-RUN -> IDLE, pc=0, done=0; start in DONE -> RUN and cycle_count=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: instruction fields, the halt encoding and fetch FSM states.
package isa_pkg;

    localparam int unsigned INSTR_W   = 9;
    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned OPERAND_W = 6;
    localparam int unsigned COUNT_W   = 16;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef logic [OPCODE_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_cycle_counter.sv
// Saturating count of executed instructions; cleared on program (re)start or reset.
module fetch_cycle_counter
#(
    parameter int unsigned W = 16
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC stepping, branch redirect, stall and halt detection.
// Optional executed-instruction counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit
#(
    parameter int unsigned             PC_W       = 10,
    parameter int unsigned             INSTR_W    = isa_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0]      HALT_INSTR = INSTR_W'(isa_pkg::HALT_INSTR)
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [PC_W-1:0]               start_addr,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [PC_W-1:0]               branch_target,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [INSTR_W-1:0]            imem_data,
    output isa_pkg::opcode_t              opcode,
    output logic                          last_bit,
    output logic [isa_pkg::OPERAND_W-1:0] operand,
    output logic                          instr_valid,
    output logic                          done,
    output logic [isa_pkg::COUNT_W-1:0]   cycle_count
);

    import isa_pkg::*;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            is_halt;

    assign is_halt = (imem_data == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Halt outranks branch; a stalled cycle freezes the PC and ignores both.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_valid = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_addr;
                end
            end
            RUN: begin
                instr_valid = !stall && !is_halt;
                if (!stall) begin
                    if (is_halt) begin
                        state_d = DONE;
                    end else if (branch_taken) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign done      = (state_q == DONE);
    assign opcode    = imem_data[8:6];
    assign last_bit  = imem_data[0];
    assign operand   = imem_data[5:0];

`ifdef FETCH_CYCLE_COUNT_EN
    logic count_clear;

    assign count_clear = start && (state_q != RUN);

    fetch_cycle_counter #(
        .W(COUNT_W)
    ) u_cycle_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (count_clear),
        .inc_i   (instr_valid),
        .count_o (cycle_count)
    );
`else
    assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;

    localparam int        PC_W  = 10;
    localparam int        DEPTH = 1024;
    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [2:0]      opcode;
    logic            last_bit;
    logic [5:0]      operand;
    logic            instr_valid;
    logic            done;
    logic [15:0]     cycle_count;

    logic [8:0] mem [DEPTH];

    int checks = 0;
    int passed = 0;

    // Reference model: program mode (0 idle, 1 running, 2 halted), PC and executed count.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .opcode        (opcode),
        .last_bit      (last_bit),
        .operand       (operand),
        .instr_valid   (instr_valid),
        .done          (done),
        .cycle_count   (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] rand_instr();
        return 9'($urandom_range(0, 510));
    endfunction

    function automatic bit m_valid();
        return (m_mode == 1) && !stall && (mem[m_pc] != HALT);
    endfunction

    function automatic int m_count();
        return CNT_EN ? m_cnt : 0;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        bit v;
        v = m_valid();
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (v && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!stall) begin
                if (mem[m_pc] == HALT) m_mode = 2;
                else if (branch_taken) m_pc = int'(branch_target);
                else m_pc = (m_pc + 1) % DEPTH;
            end
        end else if (start) begin
            m_mode = 1; m_pc = int'(start_addr); m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        start_addr = '0; branch_target = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'd0) $display("FAIL reset_addr: got %0d expected 0", imem_addr); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else passed++;
        checks++; if (cycle_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", cycle_count); else passed++;
    endtask

    task automatic test_sequential();
        logic [8:0] w;
        for (int a = 5; a <= 7; a++) mem[a] = rand_instr();
        mem[8] = HALT;
        start = 1'b1; start_addr = 10'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            w = mem[5 + i];
            checks++; if (imem_addr !== 10'(5 + i)) $display("FAIL seq_addr: got %0d expected %0d", imem_addr, 5 + i); else passed++;
            checks++; if (instr_valid !== (i < 3)) $display("FAIL seq_valid: got %b expected %b", instr_valid, (i < 3)); else passed++;
            checks++; if ({opcode, operand} !== w) $display("FAIL seq_fields: got %h expected %h", {opcode, operand}, w); else passed++;
            checks++; if (last_bit !== w[0]) $display("FAIL seq_last_bit: got %b expected %b", last_bit, w[0]); else passed++;
            tick();
        end
        checks++; if (done !== 1'b1) $display("FAIL seq_done: got %b expected 1", done); else passed++;
        checks++; if (instr_valid !== 1'b0) $display("FAIL seq_done_valid: got %b expected 0", instr_valid); else passed++;
        checks++; if (imem_addr !== 10'd8) $display("FAIL seq_done_addr: got %0d expected 8", imem_addr); else passed++;
        checks++; if (cycle_count !== 16'(CNT_EN ? 3 : 0)) $display("FAIL seq_count: got %0d expected %0d", cycle_count, CNT_EN ? 3 : 0); else passed++;
    endtask

    task automatic test_branch();
        for (int a = 0; a <= 3; a++) mem[a] = rand_instr();
        mem[40] = rand_instr();
        mem[41] = rand_instr();
        start = 1'b1; start_addr = 10'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (imem_addr !== 10'd2) $display("FAIL br_at2: got %0d expected 2", imem_addr); else passed++;
        branch_taken = 1'b1; branch_target = 10'd40;
        #1;
        checks++; if (instr_valid !== 1'b1) $display("FAIL br_valid: got %b expected 1", instr_valid); else passed++;
        tick();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 10'd40) $display("FAIL br_target: got %0d expected 40", imem_addr); else passed++;
        checks++; if (cycle_count !== 16'(m_count())) $display("FAIL br_count: got %0d expected %0d", cycle_count, m_count()); else passed++;
    endtask

    task automatic test_stall();
        int cnt_before;
        mem[10] = rand_instr();
        mem[11] = rand_instr();
        branch_taken = 1'b1; branch_target = 10'd10;
        tick();
        branch_taken = 1'b0;
        cnt_before = m_count();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            branch_taken = 1'b1; branch_target = 10'd77;
            #1;
            checks++; if (imem_addr !== 10'd10) $display("FAIL stall_addr: got %0d expected 10", imem_addr); else passed++;
            checks++; if (instr_valid !== 1'b0) $display("FAIL stall_valid: got %b expected 0", instr_valid); else passed++;
            checks++; if (cycle_count !== 16'(cnt_before)) $display("FAIL stall_count: got %0d expected %0d", cycle_count, cnt_before); else passed++;
            tick();
        end
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'd10) $display("FAIL stall_hold: got %0d expected 10", imem_addr); else passed++;
        checks++; if (instr_valid !== 1'b1) $display("FAIL stall_release_valid: got %b expected 1", instr_valid); else passed++;
        tick();
        checks++; if (imem_addr !== 10'd11) $display("FAIL stall_next: got %0d expected 11", imem_addr); else passed++;
        checks++; if (cycle_count !== 16'(m_count())) $display("FAIL stall_post_count: got %0d expected %0d", cycle_count, m_count()); else passed++;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem[1023] = rand_instr();
        mem[0] = rand_instr();
        start = 1'b1; start_addr = 10'd1023;
        tick();
        start = 1'b0;
        checks++; if (imem_addr !== 10'd1023) $display("FAIL wrap_start: got %0d expected 1023", imem_addr); else passed++;
        tick();
        checks++; if (imem_addr !== 10'd0) $display("FAIL wrap_zero: got %0d expected 0", imem_addr); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL wrap_done: got %b expected 0", done); else passed++;
    endtask

    task automatic test_priority();
        mem[30] = HALT;
        branch_taken = 1'b1; branch_target = 10'd30;
        tick();
        branch_target = 10'd50;
        #1;
        checks++; if (instr_valid !== 1'b0) $display("FAIL prio_valid: got %b expected 0", instr_valid); else passed++;
        tick();
        branch_taken = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL prio_done: got %b expected 1", done); else passed++;
        checks++; if (imem_addr !== 10'd30) $display("FAIL prio_addr: got %0d expected 30", imem_addr); else passed++;
        tick();
        checks++; if (imem_addr !== 10'd30 || done !== 1'b1) $display("FAIL prio_hold: got addr %0d done %b expected 30 1", imem_addr, done); else passed++;
    endtask

    task automatic test_abort_restart();
        for (int a = 100; a <= 105; a++) mem[a] = rand_instr();
        mem[106] = HALT;
        start = 1'b1; start_addr = 10'd100;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'd0) $display("FAIL abort_addr: got %0d expected 0", imem_addr); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else passed++;
        checks++; if (cycle_count !== 16'd0) $display("FAIL abort_count: got %0d expected 0", cycle_count); else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++; if (instr_valid !== 1'b0) $display("FAIL abort_idle_valid: got %b expected 0", instr_valid); else passed++;
            tick();
        end
        start = 1'b1; start_addr = 10'd100;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (done !== 1'b1) $display("FAIL restart_done_set: got %b expected 1", done); else passed++;
        checks++; if (cycle_count !== 16'(CNT_EN ? 6 : 0)) $display("FAIL restart_pre_count: got %0d expected %0d", cycle_count, CNT_EN ? 6 : 0); else passed++;
        start = 1'b1; start_addr = 10'd100;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b0) $display("FAIL restart_done_clr: got %b expected 0", done); else passed++;
        checks++; if (cycle_count !== 16'd0) $display("FAIL restart_count: got %0d expected 0", cycle_count); else passed++;
        checks++; if (imem_addr !== 10'd100 || instr_valid !== 1'b1) $display("FAIL restart_run: got addr %0d valid %b expected 100 1", imem_addr, instr_valid); else passed++;
    endtask

    task automatic test_random();
        logic [8:0] w;
        for (int a = 0; a < DEPTH; a++) mem[a] = ($urandom_range(0, 31) == 0) ? HALT : rand_instr();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 199) == 0);
            start         = ($urandom_range(0, 7) == 0);
            start_addr    = 10'($urandom);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_target = 10'($urandom);
            #1;
            w = mem[m_pc];
            checks++; if (imem_addr !== 10'(m_pc)) $display("FAIL rnd_addr c=%0d: got %0d expected %0d", c, imem_addr, m_pc); else passed++;
            checks++; if (instr_valid !== m_valid()) $display("FAIL rnd_valid c=%0d: got %b expected %b", c, instr_valid, m_valid()); else passed++;
            checks++; if (done !== (m_mode == 2)) $display("FAIL rnd_done c=%0d: got %b expected %b", c, done, (m_mode == 2)); else passed++;
            checks++; if (cycle_count !== 16'(m_count())) $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, cycle_count, m_count()); else passed++;
            checks++; if ({opcode, operand} !== w || last_bit !== w[0]) $display("FAIL rnd_fields c=%0d: got %h expected %h", c, {opcode, operand}, w); else passed++;
            tick();
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
        test_priority();
        test_abort_restart();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
